// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder. One 1-bit full-adder cell is used for WIDTH cycles, LSB
// first. The carry is held in a flip-flop between bits. A three-state
// controller (IDLE, SHIFT, DONE) sequences the operation.
//
// Optional feature:
//   SERIAL_ADDER_SUB_EN  when defined, adds the 'sub' input. A captured sub=1
//                        inverts B and forces the carry-in to 1, so S = A - B.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   start  in   request a new operation (accepted in IDLE or DONE)
//   A, B   in   [WIDTH] operands, captured on an accepted start
//   cin    in   carry-in, captured on an accepted start
//   sub    in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy   out  high while bits are being processed (SHIFT)
//   done   out  one-cycle pulse; S/cout/ovf hold the new result
//   S      out  [WIDTH] sum; updated only on entry to DONE
//   cout   out  carry out of the MSB
//   ovf    out  signed overflow (carry into MSB ^ carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             op_sub;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             accept;

  logic             a_bit;
  logic             b_bit;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] s_nxt;

`ifdef SERIAL_ADDER_SUB_EN
  assign op_sub = sub;
`else
  assign op_sub = 1'b0;
`endif

  // Subtraction is A + ~B + 1. Inverting B and forcing the carry at capture
  // time keeps the datapath a plain adder.
  assign b_load = op_sub ? ~B : B;
  assign c_load = op_sub ? 1'b1 : cin;

  // A start is accepted in DONE as well as in IDLE. This allows back-to-back
  // operations. A start seen during SHIFT is ignored.
  assign accept = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // NOTE: every signal assigned in an always_comb block gets a value on every
  //       path. Here that comes from the unconditional assignments at the top
  //       of the block, so no latch is inferred.
  always_comb begin
    a_bit     = a_sh[0];
    b_bit     = b_sh[0];
    sum_bit   = a_bit ^ b_bit ^ carry;
    carry_nxt = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
    // The sum bit enters from the MSB side. After WIDTH shifts, the LSB sum
    // bit has reached bit 0. The right shift is written without slicing, so
    // the expression stays legal when WIDTH is 1.
    s_nxt            = s_sh >> 1;
    s_nxt[WIDTH-1]   = sum_bit;
  end

  // NOTE: registers take non-blocking assignments (<=). Every flop then
  //       samples the values from before the edge, whatever the statement
  //       order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      S     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= b_load;
      carry <= c_load;
      cnt   <= '0;
      state <= SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_nxt;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            // On the last bit, 'carry' still holds the carry into the MSB.
            S     <= s_nxt;
            cout  <= carry_nxt;
            ovf   <= carry ^ carry_nxt;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        IDLE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl, WIDTH=8, add-only build.
// Expected results are pushed to a queue when a start is driven. A monitor
// pops an entry and compares it against S/cout/ovf on every done pulse.
// Control timing and the reset corner cases are checked by hand-written
// sequences.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         cout;
  logic         ovf;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  vec_t vecs[8];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model based on plain integer addition.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] t;
    res_t r;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    r.s    = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  // Scoreboard monitor. It samples on the falling edge, away from the
  // active clock edge.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=done exp=no_done (t=%0t)", $time);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("S", S, e.s);
        check("cout", cout, e.cout);
        check("ovf", ovf, e.ovf);
      end
    end
  end

  // Drive one start pulse. The task returns at the falling edge after the
  // accepting clock edge (E0).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit push);
    res_t r;
    @(negedge clk);
    A = a; B = b; cin = c; start = 1'b1;
    if (push) begin
      r = model(a, b, c);
      exp_q.push_back(r);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        t = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL done_timeout got=no_done exp=done (t=%0t)", $time);
  endtask

  initial begin
    int t1, t2;
    bit saw_done;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; A = '0; B = '0; cin = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state.
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_S", S, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);

    // The first start coincides with the first edge that has reset=0.
    // Timing of 0x0F+0x01.
    reset = 1'b0;
    A = 8'h0F; B = 8'h01; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h0F, 8'h01, 1'b0));
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      check($sformatf("shift%0d_busy", k), busy, 1);
      check($sformatf("shift%0d_done", k), done, 0);
      check($sformatf("shift%0d_S_hold", k), S, 0);
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    @(negedge clk);
    check("post_done", done, 0);
    check("post_busy", busy, 0);

    // A start during SHIFT and operand changes mid-operation are ignored.
    run_op(8'h01, 8'h01, 1'b0, 1);
    @(negedge clk);
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", busy, 1);
    wait_done(t1);

    // Back-to-back: start is held in DONE.
    A = 8'h03; B = 8'h05; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h03, 8'h05, 1'b0));
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done(t2);
    check("b2b_spacing", t2 - t1, 9);

    // Reset asserted at E4 aborts the operation with no done pulse.
    run_op(8'h10, 8'h20, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_S", S, 0);
    check("abort_cout", cout, 0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    run_op(8'h03, 8'h04, 1'b0, 1);
    wait_done(t1);

    // Reset overrides a simultaneous start.
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    check("rst_over_start", busy, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_over_start_idle", busy, 0);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      res_t r;
      @(negedge clk);
      A = vecs[i].a; B = vecs[i].b; cin = vecs[i].cin; start = 1'b1;
      r.s = vecs[i].s; r.cout = vecs[i].cout; r.ovf = vecs[i].ovf;
      exp_q.push_back(r);
      @(negedge clk);
      start = 1'b0;
      wait_done(t1);
    end

    // Random operands checked against the model.
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1);
      wait_done(t1);
    end

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
